// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8-bit UART transmitter.
// The serial frame is start(0), data LSB first, an optional even-parity bit, then stop(1).
// Optional feature: define UART_TX_PARITY_EN to insert the even-parity bit,
// which gives an 11-bit frame. Without it the frame is 10 bits.
//
// Handshake (valid/ready): a byte on `in` is accepted on every rising edge where
// inValid and inReady are both 1. inReady depends only on the FIFO fill level
// (not on inValid), so a producer may hold inValid high and wait for inReady.
//
// The tx line is registered from the current state. It therefore follows the FSM
// by one cycle. A byte popped on edge N appears as a falling start bit on edge N+1.
module uart_tx_buffered #(
  parameter int CLOCK_RATE = 50000000,
  parameter int BAUD_RATE  = 9600,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic [7:0]                    in,
  input  logic                          inValid,
  output logic                          inReady,
  output logic                          tx,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifoCount,
  output logic [2:0]                    dbg_state
);

  localparam int BAUD_DIV = CLOCK_RATE / BAUD_RATE;
  localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int AW       = $clog2(FIFO_DEPTH);
  localparam int CW       = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   baud_q, baud_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      data_q, data_d;
  logic            tx_q, tx_d;
  logic            done_q, done_d;

  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;

  logic            push;
  logic            pop;
  logic            baud_tick;
  logic            can_start;
  logic [7:0]      head;

  assign inReady   = (count_q != CW'(FIFO_DEPTH));
  assign push      = inValid && inReady;
  assign head      = mem_q[rd_ptr_q];
  assign baud_tick = (baud_q == BW'(BAUD_DIV - 1));
  assign can_start = en && (count_q != '0);

  assign tx        = tx_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign fifoCount = count_q;
  assign dbg_state = state_q;

  // FIFO pointer and occupancy update; a push and a pop in the same cycle leave the count unchanged.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Frame sequencing. Each state lasts one bit period.
  // A pop happens only when leaving IDLE or STOP for START.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    data_d  = data_q;
    pop     = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (can_start) begin
          state_d = S_START;
          pop     = 1'b1;
          data_d  = head;
        end
      end
      S_START: begin
        if (baud_tick) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      S_DATA: begin
        if (baud_tick) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (baud_tick) begin
          baud_d = '0;
          done_d = 1'b1;
          if (can_start) begin
            state_d = S_START;
            pop     = 1'b1;
            data_d  = head;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  // Line level for the bit that the current state represents.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = data_q[bit_q];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = ^data_q;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

  // State, counters, FIFO pointers and registered outputs. Reset aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      data_q   <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      data_q   <= data_d;
      tx_q     <= tx_d;
      done_q   <= done_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // FIFO storage write; contents need no reset because the occupancy count gates every read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in;
  end

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Testbench for uart_tx_buffered with CLOCK_RATE=16, BAUD_RATE=1 (16 cycles per bit) and FIFO_DEPTH=4.
module tb_uart_tx_buffered;

  localparam int BAUD_DIV = 16;
  localparam int DEPTH    = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * BAUD_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic [7:0] in_b = 8'h00;
  logic       inValid = 1'b0;
  logic       inReady;
  logic       tx;
  logic       busy;
  logic       done;
  logic [2:0] fifoCount;
  logic [2:0] dbg_state;

  int n_cmp = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int d0;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  uart_tx_buffered #(
    .CLOCK_RATE(16),
    .BAUD_RATE (1),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .in       (in_b),
    .inValid  (inValid),
    .inReady  (inReady),
    .tx       (tx),
    .busy     (busy),
    .done     (done),
    .fifoCount(fifoCount),
    .dbg_state(dbg_state)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The model is a queue of bytes plus a "frame in flight" with a cycle position.
  // The line level is frame bit (pos / BAUD_DIV), shown one cycle after the FSM position.
  logic [7:0] mq[$];
  bit         m_active = 0;
  int         m_pos = 0;
  logic [7:0] m_cur = 8'h00;
  logic       e_tx = 1'b1;
  logic       e_done = 1'b0;
  bit         model_ok = 0;
  int         m_sz;
  bit         end_f, start_f;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 1 && idx <= 8) return b[idx-1];
`ifdef UART_TX_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_active = 0;
      m_pos    = 0;
      e_tx     = 1'b1;
      e_done   = 1'b0;
      model_ok = 1;
    end else begin
      m_sz    = mq.size();
      e_tx    = m_active ? frame_bit(m_cur, m_pos / BAUD_DIV) : 1'b1;
      end_f   = m_active && (m_pos == FRAME - 1);
      e_done  = end_f;
      start_f = en && (m_sz > 0) && (!m_active || end_f);
      if (start_f) begin
        m_cur    = mq.pop_front();
        m_active = 1;
        m_pos    = 0;
      end else if (end_f) begin
        m_active = 0;
      end else if (m_active) begin
        m_pos++;
      end
      if (inValid && (m_sz < DEPTH)) mq.push_back(in_b);
    end
  end

  // ---------------- scoreboard: compare every cycle ----------------
  always @(negedge clk) begin
    if (model_ok) begin
      chk("tx", 32'(tx), 32'(e_tx));
      chk("busy", 32'(busy), 32'(m_active));
      chk("done", 32'(done), 32'(e_done));
      chk("fifoCount", 32'(fifoCount), 32'(mq.size()));
      chk("inReady", 32'(inReady), 32'(mq.size() != DEPTH));
    end
    if (done === 1'b1) done_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // ---------------- directed stimulus ----------------
  logic [10:0] a5_bits;

  initial begin
`ifdef UART_TX_PARITY_EN
    a5_bits = 11'b10101001010;
`else
    a5_bits = 11'b01101001010;
`endif
    // Reset values
    wait_cycles(2);
    chk("rst_tx", 32'(tx), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_count", 32'(fifoCount), 32'd0);
    rst = 1'b0;
    step();
    chk("rst_inReady", 32'(inReady), 32'd1);

    // Single byte 0xA5: tx low two edges after acceptance, then the literal bit pattern
    en = 1'b1; in_b = 8'hA5; inValid = 1'b1;
    d0 = done_cnt;
    step();
    inValid = 1'b0;
    step();
    step();
    chk("a5_start_low", 32'(tx), 32'd0);
    for (int b = 0; b < NB; b++) begin
      wait_cycles(8);
      chk($sformatf("a5_bit%0d", b), 32'(tx), 32'(a5_bits[b]));
      wait_cycles(8);
    end
    wait_cycles(4);
    chk("a5_done_once", 32'(done_cnt - d0), 32'd1);
    chk("a5_busy_low", 32'(busy), 32'd0);

    // Back-to-back 0x00, 0xFF
    d0 = done_cnt;
    in_b = 8'h00; inValid = 1'b1;
    step();
    in_b = 8'hFF;
    step();
    inValid = 1'b0;
    wait_cycles(2 * FRAME + 10);
    chk("b2b_done_twice", 32'(done_cnt - d0), 32'd2);

    // Full FIFO with en=0; the fifth byte is dropped
    en = 1'b0;
    inValid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      in_b = 8'(k);
      step();
    end
    chk("full_inReady", 32'(inReady), 32'd0);
    in_b = 8'h05;
    step();
    inValid = 1'b0;
    chk("full_count", 32'(fifoCount), 32'd4);
    d0 = done_cnt;
    en = 1'b1;
    wait_cycles(4 * FRAME + 20);
    chk("full_done4", 32'(done_cnt - d0), 32'd4);
    chk("full_drained", 32'(fifoCount), 32'd0);

    // en gating: drop en during data bit 3 of 0x3C while 0x55 waits
    d0 = done_cnt;
    in_b = 8'h3C; inValid = 1'b1;
    step();
    in_b = 8'h55;
    step();
    inValid = 1'b0;
    wait_cycles(70);
    en = 1'b0;
    wait_cycles(FRAME + 40);
    chk("gate_one_frame", 32'(done_cnt - d0), 32'd1);
    chk("gate_queued", 32'(fifoCount), 32'd1);
    chk("gate_idle", 32'(busy), 32'd0);
    en = 1'b1;
    wait_cycles(FRAME + 20);
    chk("gate_second", 32'(done_cnt - d0), 32'd2);
    chk("gate_empty", 32'(fifoCount), 32'd0);

    // Reset during data bit 5 with two bytes queued
    inValid = 1'b1;
    in_b = 8'h12;
    step();
    in_b = 8'h34;
    step();
    in_b = 8'h56;
    step();
    inValid = 1'b0;
    chk("mid_queued2", 32'(fifoCount), 32'd2);
    wait_cycles(100);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    chk("mid_rst_tx", 32'(tx), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_count", 32'(fifoCount), 32'd0);
    chk("mid_rst_inReady", 32'(inReady), 32'd1);
    rst = 1'b0;
    wait_cycles(FRAME + 20);
    chk("mid_no_frames", 32'(done_cnt - d0), 32'd0);

    // Push 0x77 on the edge that pops 0x11
    en = 1'b0;
    in_b = 8'h11; inValid = 1'b1;
    step();
    inValid = 1'b0;
    step();
    d0 = done_cnt;
    en = 1'b1; in_b = 8'h77; inValid = 1'b1;
    step();
    inValid = 1'b0;
    chk("pp_count_same", 32'(fifoCount), 32'd1);
    wait_cycles(2 * FRAME + 20);
    chk("pp_done2", 32'(done_cnt - d0), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_buffered.md
UART_TX_BUFFERED -- requirements
Module: uart_tx_buffered

Interface
REQ-001 Parameter CLOCK_RATE, default 50000000: input clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 9600: serial bit rate in bit/s.
REQ-003 Parameter FIFO_DEPTH, default 8: byte FIFO depth; power of two, 2..256.
REQ-004 clk  input  1  sole clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 en  input  1  transmit enable; gates the start of new frames only.
REQ-007 in  input  8  byte to enqueue.
REQ-008 inValid  input  1  in is valid this cycle.
REQ-009 inReady  output  1  FIFO can accept a byte this cycle.
REQ-010 tx  output  1  serial line, idle high, registered.
REQ-011 busy  output  1  a frame is in progress.
REQ-012 done  output  1  one-cycle pulse at the end of each stop bit.
REQ-013 fifoCount  output  $clog2(FIFO_DEPTH)+1  bytes currently queued.

Function
REQ-014 The block SHALL enqueue in on every rising edge where inValid and inReady are both 1.
REQ-015 inReady SHALL equal (fifoCount != FIFO_DEPTH), combinationally.
REQ-016 Bit period SHALL be BAUD_DIV = CLOCK_RATE/BAUD_RATE clk cycles, using integer division; every bit SHALL last exactly BAUD_DIV cycles.
REQ-017 Frame format SHALL be: start bit 0, data bits in[0] first through in[7], optional parity bit (REQ-028), stop bit 1.
REQ-018 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-019 Transitions SHALL be:
- IDLE->START when en=1 and the FIFO is non-empty; the head byte is popped on that edge.
- START->DATA after BAUD_DIV cycles.
- DATA->PARITY (macro defined) or DATA->STOP after 8 bits.
- PARITY->STOP after BAUD_DIV cycles.
REQ-020 At the end of STOP, the FSM SHALL go directly to START, popping the next byte on the same edge, when en=1 and the FIFO is non-empty; otherwise it SHALL go to IDLE. Back-to-back frames have no idle gap.
REQ-021 For a byte accepted into an empty FIFO while IDLE with en=1, tx SHALL go low on the second rising edge after the accepting edge.
REQ-022 busy SHALL be 1 in every state except IDLE.
REQ-023 done SHALL pulse for exactly one cycle, on the cycle in which STOP completes.
REQ-024 On a simultaneous push and pop, fifoCount SHALL remain unchanged, with no data loss or duplication.
REQ-025 A push attempted while the FIFO is full SHALL be ignored; FIFO contents and fifoCount SHALL be unchanged.
REQ-026 Deasserting en mid-frame SHALL NOT truncate the frame; no new frame SHALL start while en=0. Enqueueing SHALL continue regardless of en.

Reset
REQ-027 When rst=1 at a rising edge, the block SHALL set: state IDLE, tx=1, busy=0, done=0, fifoCount=0, FIFO pointers 0, bit and baud counters 0. This SHALL abort any frame in progress; inReady SHALL be 1 in the following cycle.

Configuration
REQ-028 With macro UART_TX_PARITY_EN defined, the block SHALL insert one even-parity bit (XOR of in[7:0]) after data bit 7, giving an 11-bit frame. Without the macro, the PARITY state and its logic SHALL be absent, giving a 10-bit frame.

Verification (CLOCK_RATE=16, BAUD_RATE=1, so BAUD_DIV=16; FIFO_DEPTH=4)
REQ-029 Single byte: push 0xA5 while IDLE with en=1 -> tx low 2 edges later, then 16 cycles each of bits 0,1,0,1,0,0,1,0,1,[0 with parity],1; done pulses once; busy returns to 0.
REQ-030 Back-to-back: push 0x00 and 0xFF on consecutive cycles -> two frames with no idle cycle between the stop bit of frame 1 and the start bit of frame 2; done pulses twice.
REQ-031 Full FIFO: hold en=0 and push 5 bytes 0x01..0x05 -> inReady=0 after the 4th push, fifoCount=4, 0x05 dropped; set en=1 -> 0x01..0x04 transmitted in order.
REQ-032 en gating: deassert en during data bit 3 of 0x3C -> frame completes unchanged; a queued 0x55 is not started until en=1.
REQ-033 Reset mid-frame: assert rst during data bit 5 with 2 bytes queued -> next cycle tx=1, busy=0, fifoCount=0, inReady=1; no further frames are sent.
REQ-034 Simultaneous push/pop: push 0x77 on the edge that pops 0x11 at fifoCount=1 -> fifoCount stays 1; 0x77 is transmitted next.
